riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu_pkg.sv | 43 ++++
 rtl/riscv_lsu_if.sv | 46 ++++
 rtl/riscv_lsu_align.sv | 46 ++++
 rtl/riscv_lsu.sv | 148 ++++++++++++++
 tb/tb_riscv_lsu.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: funct3 codes, FSM encoding, default timeout, helpers.
// No ports; imported by riscv_lsu, riscv_lsu_align and the bench.
package riscv_lsu_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    return ((f3[1:0] == SZ_H) && off[0]) ||
           ((f3[1:0] == SZ_W) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] force_align(
    input logic [2:0]  f3,
    input logic [31:0] addr
  );
    logic [31:0] a;
    a = addr;
    if (f3[1:0] == SZ_H) a[0] = 1'b0;
    if (f3[1:0] == SZ_W) a[1:0] = 2'b00;
    return a;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: pipeline request/response plus memory bus signals.
// slave = LSU side, master = pipeline/bus environment side.
interface riscv_lsu_if;

  logic        i_lsu_req;
  logic        i_lsu_wr_en;
  logic [2:0]  i_lsu_funct3;
  logic [3:0]  i_lsu_byte_sel;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic        o_lsu_stall;
  logic        o_lsu_done;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_misalign;
  logic        o_lsu_timeout;

  logic        o_bus_req;
  logic        i_bus_gnt;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_rvalid;
  logic [31:0] i_bus_rdata;

  modport slave (
    input  i_lsu_req, i_lsu_wr_en, i_lsu_funct3,
    input  i_lsu_byte_sel, i_lsu_addr, i_lsu_wdata,
    output o_lsu_stall, o_lsu_done, o_lsu_rdata,
    output o_lsu_misalign, o_lsu_timeout,
    output o_bus_req, o_bus_we, o_bus_addr,
    output o_bus_be, o_bus_wdata,
    input  i_bus_gnt, i_bus_rvalid, i_bus_rdata
  );

  modport master (
    output i_lsu_req, i_lsu_wr_en, i_lsu_funct3,
    output i_lsu_byte_sel, i_lsu_addr, i_lsu_wdata,
    input  o_lsu_stall, o_lsu_done, o_lsu_rdata,
    input  o_lsu_misalign, o_lsu_timeout,
    input  o_bus_req, o_bus_we, o_bus_addr,
    input  o_bus_be, o_bus_wdata,
    output i_bus_gnt, i_bus_rvalid, i_bus_rdata
  );

endinterface

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: combinational lane logic (be shift, store replicate,
// load extract/extend). In: funct3, byte_sel, off, wdata, rdata. Out: be, wdata_rep, rdata_ext.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [3:0]  byte_sel,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign be      = byte_sel << off;
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    wdata_rep = wdata;
    unique case (1'b1)
      (funct3[1:0] == SZ_B): wdata_rep = {4{wdata[7:0]}};
      (funct3[1:0] == SZ_H): wdata_rep = {2{wdata[15:0]}};
      default:               wdata_rep = wdata;
    endcase
  end

  always_comb begin
    rdata_ext = shifted;
    unique case (1'b1)
      (funct3 == F3_B):
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      (funct3 == F3_H):
        rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      (funct3 == F3_BU):
        rdata_ext = {24'd0, shifted[7:0]};
      (funct3 == F3_HU):
        rdata_ext = {16'd0, shifted[15:0]};
      default:
        rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit FSM bridging the pipeline to a gnt/rvalid bus.
// Ports: i_clk, i_rst (async high), lsu (riscv_lsu_if.slave). Option: RISCV_LSU_MISALIGN_EXC_EN.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  riscv_lsu_if.slave  lsu
);

  localparam logic [7:0] TO_LIM = TIMEOUT_CYCLES[7:0];

  state_t      state_q;
  state_t      state_d;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  cnt_q;
  logic        mis_q;
  logic        to_q;

  logic        accept;
  logic        mis_req;
  logic [31:0] addr_acc;
  logic [7:0]  cnt_nxt;
  logic        to_hit;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] rdata_w;

`ifdef RISCV_LSU_MISALIGN_EXC_EN
  assign mis_req  = misaligned(lsu.i_lsu_funct3, lsu.i_lsu_addr[1:0]);
  assign addr_acc = lsu.i_lsu_addr;
`else
  assign mis_req  = 1'b0;
  assign addr_acc = force_align(lsu.i_lsu_funct3, lsu.i_lsu_addr);
`endif

  assign accept  = (state_q == S_IDLE) && lsu.i_lsu_req;
  assign cnt_nxt = cnt_q + 8'd1;
  // Fires on the cycle whose increment would reach the limit.
  assign to_hit  = (cnt_nxt == TO_LIM);

  riscv_lsu_align u_align (
    .funct3    (f3_q),
    .byte_sel  (sel_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (lsu.i_bus_rdata),
    .be        (be_w),
    .wdata_rep (wdata_w),
    .rdata_ext (rdata_w)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (lsu.i_lsu_req)
          state_d = mis_req ? S_DONE : S_REQ;
      S_REQ:
        if (lsu.i_bus_gnt)
          state_d = wr_q ? S_DONE : S_RSP;
        else if (to_hit)
          state_d = S_DONE;
      S_RSP:
        if (lsu.i_bus_rvalid || to_hit)
          state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      sel_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (accept) begin
            wr_q    <= lsu.i_lsu_wr_en;
            f3_q    <= lsu.i_lsu_funct3;
            sel_q   <= lsu.i_lsu_byte_sel;
            addr_q  <= addr_acc;
            wdata_q <= lsu.i_lsu_wdata;
            rdata_q <= 32'd0;
            cnt_q   <= 8'd0;
            mis_q   <= mis_req;
            to_q    <= 1'b0;
          end
        S_REQ:
          if (lsu.i_bus_gnt) cnt_q <= 8'd0;
          else if (to_hit)   to_q  <= 1'b1;
          else               cnt_q <= cnt_nxt;
        S_RSP:
          if (lsu.i_bus_rvalid) begin
            rdata_q <= rdata_w;
          end else if (to_hit) begin
            to_q    <= 1'b1;
            rdata_q <= 32'd0;
          end else begin
            cnt_q   <= cnt_nxt;
          end
        S_DONE: begin
          mis_q <= 1'b0;
          to_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lsu.o_lsu_stall    = ~i_rst &&
                         (accept || (state_q == S_REQ) ||
                          (state_q == S_RSP));
    lsu.o_lsu_done     = (state_q == S_DONE);
    lsu.o_lsu_rdata    = (state_q == S_DONE) ? rdata_q : 32'd0;
    lsu.o_lsu_misalign = (state_q == S_DONE) && mis_q;
    lsu.o_lsu_timeout  = (state_q == S_DONE) && to_q;
    lsu.o_bus_req      = (state_q == S_REQ);
    lsu.o_bus_we       = wr_q;
    lsu.o_bus_addr     = {addr_q[31:2], 2'b00};
    lsu.o_bus_be       = be_w;
    lsu.o_bus_wdata    = wdata_w;
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed + random accesses against a byte-arithmetic model.
// Drives riscv_lsu through riscv_lsu_if with TIMEOUT_CYCLES=4.
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  localparam int TO = 4;
`ifdef RISCV_LSU_MISALIGN_EXC_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  riscv_lsu_if lsu ();

  riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .lsu   (lsu)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag,
                      input logic obs,
                      input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic void model(
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output logic [31:0] baddr,
    output logic [3:0]  be,
    output logic [3:0]  sel,
    output logic [31:0] bwd,
    output logic [31:0] ld,
    output bit          mis
  );
    int          n;
    int          off;
    logic [31:0] aa;
    logic [31:0] v;
    logic [31:0] mask;
    n     = 1 << f3[1:0];
    mis   = (a % 32'(n)) != 0;
    aa    = MIS_EN ? a : a - (a % 32'(n));
    baddr = aa - (aa % 32'd4);
    off   = int'(aa % 32'd4);
    sel   = 4'((1 << n) - 1);
    be    = 4'(((1 << n) - 1) << off);
    if (n == 1)      bwd = wd[7:0] * 32'h0101_0101;
    else if (n == 2) bwd = wd[15:0] * 32'h0001_0001;
    else             bwd = wd;
    v    = rd >> (8 * off);
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (!f3[2] && n != 4 && v[8*n-1]) v = v | ~mask;
    ld = v;
  endfunction

  task automatic scramble();
    lsu.i_lsu_req   = 1'($urandom_range(0, 1));
    lsu.i_lsu_wr_en = 1'($urandom_range(0, 1));
    lsu.i_lsu_addr  = $urandom;
    lsu.i_lsu_wdata = $urandom;
  endtask

  task automatic access(input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gd, input int rdly,
                        input logic [31:0] rd);
    logic [31:0] eaddr, ewd, eld;
    logic [3:0]  ebe, esel;
    bit          mis, emis, tout, got;
    int          k;
    model(f3, a, wd, rd, eaddr, ebe, esel, ewd, eld, mis);
    emis = MIS_EN && mis;
    tout = 1'b0;
    got  = 1'b0;
    @(negedge clk);
    lsu.i_lsu_req      = 1'b1;
    lsu.i_lsu_wr_en    = wr;
    lsu.i_lsu_funct3   = f3;
    lsu.i_lsu_byte_sel = esel;
    lsu.i_lsu_addr     = a;
    lsu.i_lsu_wdata    = wd;
    #1 chkb("stall_idle", lsu.o_lsu_stall, 1'b1);
    @(negedge clk);
    if (!emis) begin
      k = 0;
      while (!got && !tout) begin
        chkb("bus_req", lsu.o_bus_req, 1'b1);
        chkb("bus_we", lsu.o_bus_we, wr);
        chk("bus_addr", lsu.o_bus_addr, eaddr);
        chk("bus_be", 32'(lsu.o_bus_be), 32'(ebe));
        if (wr) chk("bus_wdata", lsu.o_bus_wdata, ewd);
        chkb("stall_req", lsu.o_lsu_stall, 1'b1);
        scramble();
        lsu.i_bus_rvalid = 1'($urandom_range(0, 1));
        lsu.i_bus_gnt    = (k == gd);
        if (k == gd)          got  = 1'b1;
        else if (k == TO - 1) tout = 1'b1;
        k++;
        @(negedge clk);
      end
      lsu.i_bus_gnt = 1'b0;
      if (got && !wr) begin
        k   = 0;
        got = 1'b0;
        while (!got && !tout) begin
          chkb("bus_req_rsp", lsu.o_bus_req, 1'b0);
          chkb("stall_rsp", lsu.o_lsu_stall, 1'b1);
          scramble();
          lsu.i_bus_gnt    = 1'($urandom_range(0, 1));
          lsu.i_bus_rvalid = (k == rdly);
          lsu.i_bus_rdata  = (k == rdly) ? rd : $urandom;
          if (k == rdly)        got  = 1'b1;
          else if (k == TO - 1) tout = 1'b1;
          k++;
          @(negedge clk);
        end
      end
    end
    lsu.i_lsu_req    = 1'b0;
    lsu.i_bus_gnt    = 1'b0;
    lsu.i_bus_rvalid = 1'b0;
    lsu.i_bus_rdata  = $urandom;
    #1;
    chkb("done", lsu.o_lsu_done, 1'b1);
    chkb("stall_done", lsu.o_lsu_stall, 1'b0);
    chkb("bus_req_done", lsu.o_bus_req, 1'b0);
    chkb("misalign", lsu.o_lsu_misalign, emis);
    chkb("timeout", lsu.o_lsu_timeout, tout);
    if (!wr) chk("rdata", lsu.o_lsu_rdata, (emis || tout) ? 32'd0 : eld);
    @(negedge clk);
    #1;
    chkb("done_pulse", lsu.o_lsu_done, 1'b0);
    chkb("timeout_pulse", lsu.o_lsu_timeout, 1'b0);
  endtask

  logic [2:0] ld_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

  initial begin
    bit         wr;
    logic [2:0] f3;
    lsu.i_lsu_req      = 1'b0;
    lsu.i_lsu_wr_en    = 1'b0;
    lsu.i_lsu_funct3   = 3'd0;
    lsu.i_lsu_byte_sel = 4'd0;
    lsu.i_lsu_addr     = 32'd0;
    lsu.i_lsu_wdata    = 32'd0;
    lsu.i_bus_gnt      = 1'b0;
    lsu.i_bus_rvalid   = 1'b0;
    lsu.i_bus_rdata    = 32'd0;

    #1;
    chkb("rst_done", lsu.o_lsu_done, 1'b0);
    chkb("rst_stall", lsu.o_lsu_stall, 1'b0);
    chkb("rst_bus_req", lsu.o_bus_req, 1'b0);
    chk("rst_rdata", lsu.o_lsu_rdata, 32'd0);
    chk("rst_bus_addr", lsu.o_bus_addr, 32'd0);
    chk("rst_bus_be", 32'(lsu.o_bus_be), 32'd0);
    chkb("rst_timeout", lsu.o_lsu_timeout, 1'b0);
    chkb("rst_misalign", lsu.o_lsu_misalign, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    access(1'b1, F3_B,  32'h0000_1003, 32'h0000_00AB, 0, 0, 32'd0);
    access(1'b0, F3_H,  32'h0000_2002, 32'd0, 0, 3, 32'h8001_1234);
    access(1'b0, F3_BU, 32'h0000_2001, 32'd0, 1, 0, 32'h0000_F000);
    access(1'b0, F3_W,  32'h0000_3002, 32'd0, 0, 1, 32'hDEAD_BEEF);
    access(1'b1, F3_W,  32'h0000_3002, 32'h1234_5678, 2, 0, 32'd0);
    access(1'b1, F3_W,  32'h0000_4000, 32'h1111_2222, 4, 0, 32'd0);
    access(1'b1, F3_W,  32'h0000_4000, 32'h3333_4444, 3, 0, 32'd0);
    access(1'b0, F3_W,  32'h0000_5004, 32'd0, 0, 4, 32'h5555_6666);
    access(1'b0, F3_B,  32'h0000_5007, 32'd0, 3, 3, 32'h8000_0000);

    @(negedge clk);
    lsu.i_lsu_req      = 1'b1;
    lsu.i_lsu_wr_en    = 1'b0;
    lsu.i_lsu_funct3   = F3_W;
    lsu.i_lsu_byte_sel = 4'hF;
    lsu.i_lsu_addr     = 32'h0000_6000;
    @(negedge clk);
    lsu.i_lsu_req = 1'b0;
    lsu.i_bus_gnt = 1'b1;
    @(negedge clk);
    lsu.i_bus_gnt = 1'b0;
    #1 chkb("rsp_stall", lsu.o_lsu_stall, 1'b1);
    rst = 1'b1;
    #1;
    chkb("rst_rsp_bus_req", lsu.o_bus_req, 1'b0);
    chkb("rst_rsp_stall", lsu.o_lsu_stall, 1'b0);
    chkb("rst_rsp_done", lsu.o_lsu_done, 1'b0);
    chk("rst_rsp_addr", lsu.o_bus_addr, 32'd0);
    chk("rst_rsp_rdata", lsu.o_lsu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lsu.i_bus_rvalid = 1'b1;
    lsu.i_bus_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    lsu.i_bus_rvalid = 1'b0;
    #1 chkb("rst_no_done", lsu.o_lsu_done, 1'b0);
    @(negedge clk);
    #1 chkb("rst_no_done2", lsu.o_lsu_done, 1'b0);
    access(1'b1, F3_W, 32'h0000_7008, 32'h89AB_CDEF, 0, 0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      access(wr, f3, $urandom, $urandom,
             $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
